// File: rtl/vga_frame_reader.sv
// 640x480@60 Hz VGA scan-out of a 64x64x1 frame buffer, each bit shown as a 4x4 block
// in a centred 256x256 window; sync, colour and frame_start share one 2-cycle pipeline.
module vga_frame_reader #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int IMG_X0    = 192,
    parameter int IMG_Y0    = 112
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    output logic [11:0] rdaddress,
    input  logic        q,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] X_START  = 10'(IMG_X0);
    localparam logic [9:0] X_END    = 10'(IMG_X0 + 256);
    localparam logic [9:0] Y_START  = 10'(IMG_Y0);
    localparam logic [9:0] Y_END    = 10'(IMG_Y0 + 256);

    logic [9:0] r_h_count;
    logic [9:0] r_v_count;

    logic       w_in_image;
    logic       w_visible;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_first;
    logic [5:0] w_col;
    logic [5:0] w_row;
    logic       w_pix_on;

    logic       r_in_image_d;
    logic       r_visible_d;
    logic       r_hs_d;
    logic       r_vs_d;
    logic       r_first_d;
    logic       r_display_en;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_start;
    logic [3:0] r_colour;

    // Pixel and line counters; wrap straight from the last position to (0,0).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_h_count <= 10'd0;
            r_v_count <= 10'd0;
        end else if (r_h_count == H_LAST) begin
            r_h_count <= 10'd0;
            if (r_v_count == V_LAST) begin
                r_v_count <= 10'd0;
            end else begin
                r_v_count <= r_v_count + 10'd1;
            end
        end else begin
            r_h_count <= r_h_count + 10'd1;
        end
    end

    // Stage-0 decode; the block index is bits [7:2] of the 10-bit offset into the window.
    always_comb begin
        w_in_image = (r_h_count >= X_START) && (r_h_count < X_END) &&
                     (r_v_count >= Y_START) && (r_v_count < Y_END);
        w_visible  = (r_h_count < H_VIS) && (r_v_count < V_VIS);
        w_hs_raw   = (r_h_count >= HS_START) && (r_h_count < HS_END);
        w_vs_raw   = (r_v_count >= VS_START) && (r_v_count < VS_END);
        w_first    = (r_h_count == 10'd0) && (r_v_count == 10'd0);
        w_col      = 6'((r_h_count - X_START) >> 2);
        w_row      = 6'((r_v_count - Y_START) >> 2);
        if (w_in_image) begin
            rdaddress = {w_row, w_col};
        end else begin
            rdaddress = 12'd0;
        end
    end

    // Stage-1 flags travel alongside the RAM read so they line up with q.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_in_image_d <= 1'b0;
            r_visible_d  <= 1'b0;
            r_hs_d       <= 1'b0;
            r_vs_d       <= 1'b0;
            r_first_d    <= 1'b0;
        end else begin
            r_in_image_d <= w_in_image;
            r_visible_d  <= w_visible;
            r_hs_d       <= w_hs_raw;
            r_vs_d       <= w_vs_raw;
            r_first_d    <= w_first;
        end
    end

    // Display mode only changes at (0,0) so a frame is never torn.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_display_en <= 1'b0;
        end else if (w_first) begin
            r_display_en <= enable;
        end else begin
            r_display_en <= r_display_en;
        end
    end

    assign w_pix_on = r_display_en && r_in_image_d && r_visible_d;

    // Stage-2 output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
            r_colour      <= 4'd0;
        end else begin
            r_hsync       <= ~r_hs_d;
            r_vsync       <= ~r_vs_d;
            r_frame_start <= r_first_d;
            r_colour      <= w_pix_on ? {4{q}} : 4'd0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign red         = r_colour;
    assign green       = r_colour;
    assign blue        = r_colour;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a small-geometry instance for frame/enable/reset behaviour,
// a default instance for line timing, and a compact-line instance to reach the address corners.
module tb_vga_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Small geometry: 24-cycle lines, 13-line frames, window origin (4,2).
    localparam int S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 8,  S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_X0 = 4,  S_Y0 = 2;
    localparam int S_HT = 24, S_FT = 312;

    logic        sm_rst_n, sm_en, sm_q, sm_pat;
    logic [11:0] sm_addr;
    logic        sm_hs, sm_vs, sm_fs;
    logic [3:0]  sm_r, sm_g, sm_b;

    logic        aux_rst_n;
    logic        def_en, def_q, def_hs, def_vs, def_fs;
    logic [11:0] def_addr;
    logic [3:0]  def_r, def_g, def_b;
    logic        map_en, map_q, map_hs, map_vs, map_fs;
    logic [11:0] map_addr;
    logic [3:0]  map_r, map_g, map_b;

    vga_frame_reader #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .IMG_X0(S_X0), .IMG_Y0(S_Y0)
    ) u_sm (
        .clock(clk), .reset_n(sm_rst_n), .enable(sm_en), .rdaddress(sm_addr), .q(sm_q),
        .hsync(sm_hs), .vsync(sm_vs), .red(sm_r), .green(sm_g), .blue(sm_b),
        .frame_start(sm_fs)
    );

    vga_frame_reader u_def (
        .clock(clk), .reset_n(aux_rst_n), .enable(def_en), .rdaddress(def_addr), .q(def_q),
        .hsync(def_hs), .vsync(def_vs), .red(def_r), .green(def_g), .blue(def_b),
        .frame_start(def_fs)
    );

    vga_frame_reader #(
        .H_VISIBLE(260), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(258), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .IMG_X0(3), .IMG_Y0(2)
    ) u_map (
        .clock(clk), .reset_n(aux_rst_n), .enable(map_en), .rdaddress(map_addr), .q(map_q),
        .hsync(map_hs), .vsync(map_vs), .red(map_r), .green(map_g), .blue(map_b),
        .frame_start(map_fs)
    );

    // Synchronous-read RAM models: all-ones, or a checkerboard of col[0]^row[0].
    always @(posedge clk) begin
        sm_q  <= sm_pat ? (sm_addr[0] ^ sm_addr[6]) : 1'b1;
        def_q <= 1'b1;
        map_q <= 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sm_exp_rgb(int h, int v, bit en, bit pat);
        logic b;
        if (!(en && h >= S_X0 && h < S_HV && v >= S_Y0 && v < S_VV)) return 32'h000;
        b = pat ? 1'((((h - S_X0) / 4) + ((v - S_Y0) / 4)) % 2) : 1'b1;
        return b ? 32'hFFF : 32'h000;
    endfunction

    function automatic logic [31:0] sm_exp_addr(int h, int v);
        if (h >= S_X0 && h < S_X0 + 256 && v >= S_Y0 && v < S_Y0 + 256)
            return 32'(((v - S_Y0) / 4) * 64 + (h - S_X0) / 4);
        return 32'd0;
    endfunction

    task automatic sm_check_reset(input string tag);
        check_val({tag, " hsync"}, 32'(sm_hs), 32'd1);
        check_val({tag, " vsync"}, 32'(sm_vs), 32'd1);
        check_val({tag, " rgb"}, 32'({sm_r, sm_g, sm_b}), 32'h000);
        check_val({tag, " frame_start"}, 32'(sm_fs), 32'd0);
        check_val({tag, " rdaddress"}, 32'(sm_addr), 32'd0);
    endtask

    // Entered with outputs showing position 0; leaves with outputs at position 0 of the next frame.
    task automatic scan_frame(input bit en_shown, input bit pat_sel, input int chg_p, input bit chg_val);
        int h, v, ah, av, hs_low, vs_low;
        sm_pat = pat_sel;
        hs_low = 0;
        vs_low = 0;
        for (int p = 0; p < S_FT; p++) begin
            h  = p % S_HT;
            v  = p / S_HT;
            ah = ((p + 2) % S_FT) % S_HT;
            av = ((p + 2) % S_FT) / S_HT;
            check_val($sformatf("sm frame_start p=%0d", p), 32'(sm_fs), (p == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("sm hsync p=%0d", p), 32'(sm_hs), (h >= 18 && h < 21) ? 32'd0 : 32'd1);
            check_val($sformatf("sm vsync p=%0d", p), 32'(sm_vs), (v >= 9 && v < 11) ? 32'd0 : 32'd1);
            check_val($sformatf("sm rgb p=%0d", p), 32'({sm_r, sm_g, sm_b}), sm_exp_rgb(h, v, en_shown, pat_sel));
            check_val($sformatf("sm rdaddress p=%0d", p), 32'(sm_addr), sm_exp_addr(ah, av));
            if (!sm_hs) hs_low++;
            if (!sm_vs) vs_low++;
            if (p == chg_p) sm_en = chg_val;
            @(negedge clk);
        end
        check_val("sm hsync low cycles per frame", 32'(hs_low), 32'd39);
        check_val("sm vsync low cycles per frame", 32'(vs_low), 32'd48);
    endtask

    task automatic run_small();
        @(negedge clk);
        check_val("sm first cycle frame_start", 32'(sm_fs), 32'd0);
        check_val("sm first cycle rdaddress", 32'(sm_addr), 32'd0);
        @(negedge clk);
        scan_frame(1'b1, 1'b0, -1, 1'b0);
        scan_frame(1'b1, 1'b1, 130, 1'b0);
        scan_frame(1'b0, 1'b1, 130, 1'b1);
        scan_frame(1'b1, 1'b1, -1, 1'b0);
        repeat (128) @(negedge clk);
        check_val("sm pre-reset rgb at (8,5)", 32'({sm_r, sm_g, sm_b}), 32'hFFF);
        check_val("sm pre-reset rdaddress at (10,5)", 32'(sm_addr), 32'd1);
        sm_rst_n = 1'b0;
        sm_en    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sm_check_reset($sformatf("sm mid-frame reset c%0d", i));
        end
        sm_rst_n = 1'b1;
        @(negedge clk);
        check_val("sm after release frame_start", 32'(sm_fs), 32'd0);
        check_val("sm after release rgb", 32'({sm_r, sm_g, sm_b}), 32'h000);
        check_val("sm after release rdaddress", 32'(sm_addr), 32'd0);
        @(negedge clk);
        scan_frame(1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic run_def();
        int hs_low = 0;
        int fall1  = -1;
        int fall2  = -1;
        logic prev = 1'b1;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 1700; p++) begin
            if (!def_hs) begin
                if (p < 800) hs_low++;
                if (prev) begin
                    if (fall1 < 0) fall1 = p;
                    else if (fall2 < 0) fall2 = p;
                end
            end
            prev = def_hs;
            if (p == 655 || p == 752) check_val($sformatf("def hsync p=%0d", p), 32'(def_hs), 32'd1);
            if (p == 656 || p == 751) check_val($sformatf("def hsync p=%0d", p), 32'(def_hs), 32'd0);
            if (p == 300) check_val("def rgb outside window", 32'({def_r, def_g, def_b}), 32'h000);
            if (p == 700) check_val("def vsync line 0", 32'(def_vs), 32'd1);
            if (p == 190) check_val("def rdaddress at (192,0)", 32'(def_addr), 32'd0);
            @(negedge clk);
        end
        check_val("def hsync low cycles", 32'(hs_low), 32'd96);
        check_val("def hsync first fall", 32'(fall1), 32'd656);
        check_val("def hsync period", 32'(fall2 - fall1), 32'd800);
    endtask

    task automatic run_map();
        int kpos = 0;
        int pts[7]  = '{528, 529, 533, 1581, 67849, 67850, 67857};
        int exps[7] = '{0, 0, 1, 64, 4095, 0, 0};
        for (int i = 0; i < 7; i++) begin
            repeat (pts[i] - kpos) @(negedge clk);
            kpos = pts[i];
            check_val($sformatf("map rdaddress pos=%0d", pts[i]), 32'(map_addr), 32'(exps[i]));
        end
    endtask

    initial begin
        sm_rst_n  = 1'b0;
        aux_rst_n = 1'b0;
        sm_en     = 1'b0;
        sm_pat    = 1'b0;
        def_en    = 1'b1;
        map_en    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sm_check_reset($sformatf("reset hold c%0d", i));
        end
        sm_en     = 1'b1;
        sm_rst_n  = 1'b1;
        aux_rst_n = 1'b1;
        fork
            run_small();
            run_def();
            run_map();
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
